// File: rtl/puf_frame_link.sv
// Serial<->parallel framing link between a PUF core and a narrow LANE_W-bit lane.
// Optional parity beats on both directions are enabled by defining PUF_LINK_PARITY_EN.
module puf_frame_link #(
   parameter int LANE_W    = 1,
   parameter int RX_FRAME  = 40,
   parameter int NORM_MOD  = 34,
   parameter int DEBUG_MOD = 157
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_rx_valid,
   input  logic [LANE_W-1:0]    i_rx_data,
   output logic                 o_rx_ready,
   output logic                 o_req_valid,
   output logic [RX_FRAME-1:0]  o_req_frame,
   input  logic                 i_req_ready,
   input  logic                 i_rsp_valid,
   input  logic                 i_rsp_mode,
   input  logic [DEBUG_MOD-1:0] i_rsp_frame,
   output logic                 o_rsp_ready,
   output logic                 o_tx_valid,
   output logic [LANE_W-1:0]    o_tx_data,
   input  logic                 i_tx_ready,
   output logic                 o_rx_err
);

   localparam int RX_BEATS = (RX_FRAME + LANE_W - 1) / LANE_W;
   localparam int N_BEATS  = (NORM_MOD + LANE_W - 1) / LANE_W;
   localparam int D_BEATS  = (DEBUG_MOD + LANE_W - 1) / LANE_W;
`ifdef PUF_LINK_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int RX_LAST = RX_BEATS - 1 + PAR;
   localparam int TXB_W   = (D_BEATS + PAR) * LANE_W;
   localparam int CW      = $clog2(D_BEATS + RX_BEATS + 2);

   typedef enum logic {RX_SHIFT, RX_HOLD} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   rx_state_t           rx_state, rx_state_n;
   logic [CW-1:0]       rx_cnt, rx_cnt_n;
   logic [RX_FRAME-1:0] rx_frame;
   logic                rx_fire, rx_last_beat, par_ok;

   tx_state_t           tx_state, tx_state_n;
   logic [CW-1:0]       tx_cnt, tx_cnt_n, tx_last, tx_last_n;
   logic [TXB_W-1:0]    tx_buf, cap_buf;
   logic                tx_cap, tx_fire;

   assign o_rx_ready   = (rx_state == RX_SHIFT);
   assign o_req_valid  = (rx_state == RX_HOLD);
   assign o_req_frame  = rx_frame;
   assign rx_fire      = i_rx_valid && o_rx_ready;
   assign rx_last_beat = (rx_cnt == CW'(RX_LAST));

`ifdef PUF_LINK_PARITY_EN
   logic drop, rx_err;
   // The parity beat arrives after the whole frame is already stored.
   assign par_ok   = (i_rx_data[0] == ^rx_frame);
   assign drop     = rx_fire && rx_last_beat && !par_ok;
   assign o_rx_err = rx_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_err <= 1'b0;
      else        rx_err <= drop;
   end
`else
   assign par_ok   = 1'b1;
   assign o_rx_err = 1'b0;
`endif

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      case (rx_state)
         RX_SHIFT: begin
            if (rx_fire) begin
               if (rx_last_beat) begin
                  rx_cnt_n = '0;
                  if (par_ok) rx_state_n = RX_HOLD;
               end else begin
                  rx_cnt_n = rx_cnt + CW'(1);
               end
            end
         end
         RX_HOLD: begin
            if (i_req_ready) rx_state_n = RX_SHIFT;
         end
         default: rx_state_n = RX_SHIFT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_SHIFT;
         rx_cnt   <= '0;
         rx_frame <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         // Only real frame bits are stored; lane padding in the last beat is dropped here.
         for (int i = 0; i < RX_FRAME; i++) begin
            if (rx_fire && rx_cnt == CW'(i / LANE_W)) rx_frame[i] <= i_rx_data[i % LANE_W];
         end
      end
   end

   assign o_rsp_ready = (tx_state == TX_IDLE);
   assign o_tx_valid  = (tx_state == TX_SEND);
   assign o_tx_data   = o_tx_valid ? tx_buf[LANE_W-1:0] : '0;
   assign tx_cap      = i_rsp_valid && o_rsp_ready;
   assign tx_fire     = o_tx_valid && i_tx_ready;

   // Capture image: payload masked to the selected length, parity beat right after it.
   always_comb begin
      cap_buf = '0;
      for (int i = 0; i < DEBUG_MOD; i++) begin
         if (i_rsp_mode || i < NORM_MOD) cap_buf[i] = i_rsp_frame[i];
      end
`ifdef PUF_LINK_PARITY_EN
      if (i_rsp_mode) cap_buf[D_BEATS*LANE_W] = ^i_rsp_frame;
      else            cap_buf[N_BEATS*LANE_W] = ^i_rsp_frame[NORM_MOD-1:0];
`endif
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_last_n  = tx_last;
      case (tx_state)
         TX_IDLE: begin
            if (tx_cap) begin
               tx_state_n = TX_SEND;
               tx_cnt_n   = '0;
               tx_last_n  = i_rsp_mode ? CW'(D_BEATS - 1 + PAR) : CW'(N_BEATS - 1 + PAR);
            end
         end
         TX_SEND: begin
            if (tx_fire) begin
               if (tx_cnt == tx_last) begin
                  tx_state_n = TX_IDLE;
                  tx_cnt_n   = '0;
               end else begin
                  tx_cnt_n = tx_cnt + CW'(1);
               end
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_last  <= '0;
         tx_buf   <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_last  <= tx_last_n;
         if (tx_cap)       tx_buf <= cap_buf;
         else if (tx_fire) tx_buf <= tx_buf >> LANE_W;
      end
   end

endmodule

// File: tb/tb_puf_frame_link.sv
// Bench for puf_frame_link: one LANE_W=1 and one LANE_W=8 instance, random frames
// checked against a bit-slicing reference model; honours PUF_LINK_PARITY_EN.
module tb_puf_frame_link;

   localparam int RXF = 40;
   localparam int NM  = 34;
   localparam int DM  = 157;
`ifdef PUF_LINK_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // sel picks which instance the shared stimulus drives: 0 -> LANE_W=1, 1 -> LANE_W=8
   logic          sel = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          req_ready = 1'b0;
   logic          rsp_valid = 1'b0;
   logic          rsp_mode = 1'b0;
   logic [DM-1:0] rsp_frame = '0;
   logic          tx_ready = 1'b0;

   logic          rx_ready_a, req_valid_a, rsp_ready_a, tx_valid_a, rx_err_a;
   logic [RXF-1:0] req_frame_a;
   logic [0:0]    tx_data_a;
   logic          rx_ready_b, req_valid_b, rsp_ready_b, tx_valid_b, rx_err_b;
   logic [RXF-1:0] req_frame_b;
   logic [7:0]    tx_data_b;

   wire           rx_ready  = sel ? rx_ready_b  : rx_ready_a;
   wire           req_valid = sel ? req_valid_b : req_valid_a;
   wire [RXF-1:0] req_frame = sel ? req_frame_b : req_frame_a;
   wire           rsp_ready = sel ? rsp_ready_b : rsp_ready_a;
   wire           tx_valid  = sel ? tx_valid_b  : tx_valid_a;
   wire [7:0]     tx_data   = sel ? tx_data_b   : {7'b0, tx_data_a};
   wire           rx_err    = sel ? rx_err_b    : rx_err_a;

   puf_frame_link #(.LANE_W(1), .RX_FRAME(RXF), .NORM_MOD(NM), .DEBUG_MOD(DM)) u_a (
      .clk(clk), .rst_n(rst_n),
      .i_rx_valid(rx_valid && !sel), .i_rx_data(rx_data[0:0]), .o_rx_ready(rx_ready_a),
      .o_req_valid(req_valid_a), .o_req_frame(req_frame_a), .i_req_ready(req_ready && !sel),
      .i_rsp_valid(rsp_valid && !sel), .i_rsp_mode(rsp_mode), .i_rsp_frame(rsp_frame),
      .o_rsp_ready(rsp_ready_a), .o_tx_valid(tx_valid_a), .o_tx_data(tx_data_a),
      .i_tx_ready(tx_ready && !sel), .o_rx_err(rx_err_a));

   puf_frame_link #(.LANE_W(8), .RX_FRAME(RXF), .NORM_MOD(NM), .DEBUG_MOD(DM)) u_b (
      .clk(clk), .rst_n(rst_n),
      .i_rx_valid(rx_valid && sel), .i_rx_data(rx_data), .o_rx_ready(rx_ready_b),
      .o_req_valid(req_valid_b), .o_req_frame(req_frame_b), .i_req_ready(req_ready && sel),
      .i_rsp_valid(rsp_valid && sel), .i_rsp_mode(rsp_mode), .i_rsp_frame(rsp_frame),
      .o_rsp_ready(rsp_ready_b), .o_tx_valid(tx_valid_b), .o_tx_data(tx_data_b),
      .i_tx_ready(tx_ready && sel), .o_rx_err(rx_err_b));

   // Reference: beat k of a response is payload bits [k*L +: L], zero beyond the selected
   // length; the optional final beat carries even parity of the payload.
   function automatic logic [7:0] rsp_beat(input logic [DM-1:0] f, input logic mode,
                                           input int k, input int L);
      int len = mode ? DM : NM;
      int nb = (len + L - 1) / L;
      logic par = 1'b0;
      logic [7:0] b = '0;
      for (int i = 0; i < len; i++) par ^= f[i];
      if (k == nb) b[0] = par;
      else for (int j = 0; j < L; j++) if (k*L + j < len) b[j] = f[k*L + j];
      return b;
   endfunction

   function automatic logic [DM-1:0] rand_frame();
      logic [DM-1:0] f;
      for (int i = 0; i < DM; i++) f[i] = 1'($urandom);
      return f;
   endfunction

   task automatic send_req(input logic [RXF-1:0] f, input int nsend, input bit bad);
      int L = sel ? 8 : 1;
      int nb = (RXF + L - 1) / L;
      for (int k = 0; k < nsend; k++) begin
         int t = 0;
         rx_valid = 1'b1;
         for (int j = 0; j < 8; j++) begin
            if (k < nb && j < L && k*L + j < RXF) rx_data[j] = f[k*L + j];
            else rx_data[j] = 1'($urandom);
         end
         if (k == nb) rx_data[0] = (^f) ^ bad;
         while (rx_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
         checks++;
         if (t >= 100) begin errors++; $display("FAIL rx_ready_timeout beat=%0d", k); end
         @(negedge clk);
         if (k < nb + PAR - 1) begin
            checks++;
            if (req_valid !== 1'b0) begin
               errors++; $display("FAIL req_early beat=%0d got=%b want=0", k, req_valid);
            end
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic take_req(input logic [RXF-1:0] f, input int delay);
      req_ready = 1'b0;
      for (int c = 0; c < delay; c++) begin
         checks++;
         if (req_valid !== 1'b1 || rx_ready !== 1'b0 || req_frame !== f) begin
            errors++;
            $display("FAIL req_hold c=%0d valid=%b ready=%b frame=%h want 1/0/%h",
                     c, req_valid, rx_ready, req_frame, f);
         end
         rx_valid = 1'b1;
         rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      checks++;
      if (req_valid !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_release valid=%b ready=%b want 0/1", req_valid, rx_ready);
      end
   endtask

   task automatic do_req(input logic [RXF-1:0] f, input int delay);
      int L = sel ? 8 : 1;
      send_req(f, (RXF + L - 1) / L + PAR, 1'b0);
      checks++;
      if (req_valid !== 1'b1 || req_frame !== f || rx_err !== 1'b0) begin
         errors++;
         $display("FAIL req_deliver valid=%b err=%b frame=%h want 1/0/%h",
                  req_valid, rx_err, req_frame, f);
      end
      take_req(f, delay);
   endtask

   // pat: 0 ready always, 1 ready toggles 1/0, 2 random ready
   task automatic run_rsp(input logic mode, input logic [DM-1:0] f, input int pat);
      int L = sel ? 8 : 1;
      int n = ((mode ? DM : NM) + L - 1) / L + PAR;
      int idx = 0;
      int cyc = 0;
      logic [7:0] exp;
      checks++;
      if (rsp_ready !== 1'b1) begin errors++; $display("FAIL rsp_ready_idle got=%b want=1", rsp_ready); end
      rsp_valid = 1'b1;
      rsp_mode = mode;
      rsp_frame = f;
      @(negedge clk);
      // Keep offering a different response while busy; it must not be taken.
      rsp_mode = ~mode;
      rsp_frame = rand_frame();
      while (idx < n && cyc < 1000) begin
         tx_ready = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom);
         exp = rsp_beat(f, mode, idx, L);
         checks++;
         if (tx_valid !== 1'b1 || rsp_ready !== 1'b0 || tx_data !== exp) begin
            errors++;
            $display("FAIL tx_beat idx=%0d valid=%b rsp_ready=%b data=%h want 1/0/%h",
                     idx, tx_valid, rsp_ready, tx_data, exp);
         end
         if (tx_ready) begin
            if (idx == n - 1) rsp_valid = 1'b0;
            idx++;
         end
         cyc++;
         @(negedge clk);
      end
      rsp_valid = 1'b0;
      tx_ready = 1'b0;
      checks++;
      if (idx < n) begin errors++; $display("FAIL tx_timeout sent=%0d want=%0d", idx, n); end
      checks++;
      if (tx_valid !== 1'b0 || rsp_ready !== 1'b1 || tx_data !== 8'h00) begin
         errors++;
         $display("FAIL tx_done valid=%b rsp_ready=%b data=%h want 0/1/00", tx_valid, rsp_ready, tx_data);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #0;
         checks++;
         if (rx_ready !== 1'b1 || rsp_ready !== 1'b1 || req_valid !== 1'b0 || tx_valid !== 1'b0 ||
             tx_data !== 8'h00 || req_frame !== '0 || rx_err !== 1'b0) begin
            errors++;
            $display("FAIL %s sel=%0d rxr=%b rspr=%b reqv=%b txv=%b txd=%h frame=%h err=%b want 1 1 0 0 00 0 0",
                     tag, s, rx_ready, rsp_ready, req_valid, tx_valid, tx_data, req_frame, rx_err);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_request();
      sel = 1'b0;
      do_req({32'd1024, 4'b1000, 4'b0001}, 2);
      checks++;
      if (40'h0000_0400_81 !== {32'd1024, 4'b1000, 4'b0001}) begin errors++; $display("FAIL const"); end
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int r = 0; r < 4; r++) do_req({8'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_hold();
      sel = 1'b1;
      do_req({8'($urandom), 32'($urandom)}, 10);
   endtask

   task automatic test_response();
      sel = 1'b0;
      run_rsp(1'b0, {rand_frame() >> 34, 34'h2_AAAA_5555}, 0);
      sel = 1'b1;
      run_rsp(1'b1, rand_frame(), 1);
      run_rsp(1'b1, {DM{1'b1}}, 1);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int r = 0; r < 2; r++) run_rsp(1'($urandom), rand_frame(), 2);
      end
   endtask

   task automatic test_concurrent();
      logic [RXF-1:0] f = {8'($urandom), 32'($urandom)};
      logic [DM-1:0] g = rand_frame();
      sel = 1'b0;
      fork
         do_req(f, 1);
         run_rsp(1'b0, g, 2);
      join
   endtask

   task automatic test_reset_mid();
      logic [RXF-1:0] f = {8'($urandom), 32'($urandom)};
      sel = 1'b0;
      send_req({8'($urandom), 32'($urandom)}, 17, 1'b0);
      rsp_valid = 1'b1;
      rsp_mode = 1'b1;
      rsp_frame = rand_frame();
      tx_ready = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid");
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (tx_valid !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle txv=%b reqv=%b want 0/0", tx_valid, req_valid);
         end
      end
      tx_ready = 1'b0;
      do_req(f, 0);
      run_rsp(1'b1, rand_frame(), 0);
   endtask

   task automatic test_parity();
      logic [RXF-1:0] f = {8'($urandom), 32'($urandom)};
      sel = 1'b1;
`ifdef PUF_LINK_PARITY_EN
      send_req(f, (RXF + 7) / 8 + 1, 1'b1);
      checks++;
      if (rx_err !== 1'b1 || req_valid !== 1'b0 || rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL par_drop err=%b reqv=%b rxr=%b want 1/0/1", rx_err, req_valid, rx_ready);
      end
      @(negedge clk);
      checks++;
      if (rx_err !== 1'b0 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL par_pulse err=%b reqv=%b want 0/0", rx_err, req_valid);
      end
`endif
      do_req(f, 0);
      checks++;
      if (rx_err !== 1'b0) begin errors++; $display("FAIL rx_err_idle got=%b want=0", rx_err); end
   endtask

   initial begin
      test_reset();
      test_request();
      test_hold();
      test_response();
      test_concurrent();
      test_reset_mid();
      test_parity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
